instruction_sequencer: RTL and testbench

// Upstream feeder for the cpu: buffers 16-bit instruction words from the host in a FIFO.

---
 rtl/instruction_sequencer.sv | 93 +++++++++
 tb/tb_instruction_sequencer.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/instruction_sequencer.sv
// instruction_sequencer: FIFO-buffered cpu instruction feeder with burst-aware issue control
module instruction_sequencer #(
  parameter int DEPTH             = 16,
  parameter int BURST_WORDS       = 5,
  parameter int INIT_RESET_CYCLES = 2
) (
  input  logic                     clock_in,
  input  logic                     reset_in,
  input  logic [15:0]              instr_in,
  input  logic                     instr_valid_in,
  output logic                     instr_ready_out,
  output logic [15:0]              current_instruction_out,
  output logic [$clog2(DEPTH):0]   fifo_count_out,
  output logic                     burst_read_window_out,
  output logic                     busy_out
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(BURST_WORDS + INIT_RESET_CYCLES + 1) + 1;
  localparam logic [15:0] NOP = 16'h0000;
  localparam logic [15:0] RST = 16'h000C;
  localparam logic [AW:0] LAUNCH = (AW+1)'(BURST_WORDS + 1);
  typedef enum logic [1:0] {INIT, RUN, BURST_WR, BURST_RD} state_t;
  state_t state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0] count;
  logic [15:0] mem [DEPTH];
  logic [15:0] head, out_nx;
  logic push, pop, win_nx, is_bw, is_br;
  assign head = mem[rd_ptr];
  assign is_bw = head[1:0] == 2'b11 && head[2];
  assign is_br = head[1:0] == 2'b11 && !head[2];
  assign instr_ready_out = !reset_in && count < (AW+1)'(DEPTH);
  assign push = instr_valid_in && instr_ready_out;
  assign fifo_count_out = count;
  assign busy_out = state != RUN;
  always_comb begin
    state_nx = state;
    cnt_nx = cnt;
    pop = 1'b0;
    out_nx = NOP;
    win_nx = 1'b0;
    case (state)
      INIT: begin
        out_nx = cnt != '0 ? RST : NOP;
        cnt_nx = cnt != '0 ? cnt - CW'(1) : cnt;
        state_nx = cnt != '0 ? INIT : RUN;
      end
      RUN: begin
        // a burst write only launches once its whole payload is buffered
        if (count != '0 && !(is_bw && count < LAUNCH)) begin
          pop = 1'b1;
          out_nx = head;
          state_nx = is_bw ? BURST_WR : is_br ? BURST_RD : RUN;
          cnt_nx = CW'(BURST_WORDS);
        end
      end
      BURST_WR: begin
        pop = 1'b1;
        out_nx = head;
        cnt_nx = cnt - CW'(1);
        state_nx = cnt == CW'(1) ? RUN : BURST_WR;
      end
      default: begin
        win_nx = 1'b1;
        cnt_nx = cnt - CW'(1);
        state_nx = cnt == CW'(1) ? RUN : BURST_RD;
      end
    endcase
  end
  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      state <= INIT;
      cnt <= CW'(INIT_RESET_CYCLES - 1);
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
      current_instruction_out <= RST;
      burst_read_window_out <= 1'b0;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
      rd_ptr <= rd_ptr + AW'(pop);
      wr_ptr <= wr_ptr + AW'(push);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
      current_instruction_out <= out_nx;
      burst_read_window_out <= win_nx;
    end
  end
  always_ff @(posedge clock_in) begin
    if (push) mem[wr_ptr] <= instr_in;
  end
endmodule

// File: tb/tb_instruction_sequencer.sv
// tb_instruction_sequencer: table vectors, directed burst sequences and randomized traffic vs a queue model
module tb_instruction_sequencer;
  localparam int DEPTH = 16;
  localparam int BW = 5;
  localparam int INIT = 2;
  logic clk = 1'b0;
  logic reset_in = 1'b1;
  logic [15:0] instr_in = '0;
  logic valid = 1'b0;
  logic ready, busy, win;
  logic [15:0] out;
  logic [4:0] count;
  int compared = 0;
  int mismatched = 0;
  logic [15:0] q[$];
  int init_left, wr_left, rd_left;
  logic [15:0] m_out;
  logic m_win;

  instruction_sequencer #(.DEPTH(DEPTH), .BURST_WORDS(BW), .INIT_RESET_CYCLES(INIT)) dut (
    .clock_in(clk), .reset_in(reset_in), .instr_in(instr_in), .instr_valid_in(valid),
    .instr_ready_out(ready), .current_instruction_out(out), .fifo_count_out(count),
    .burst_read_window_out(win), .busy_out(busy));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge(input logic r, input logic v, input logic [15:0] d);
    logic [15:0] h;
    logic pushing;
    pushing = v && !r && q.size() < DEPTH;
    m_win = 1'b0;
    if (r) begin
      q.delete();
      init_left = INIT;
      wr_left = 0;
      rd_left = 0;
      m_out = 16'h000C;
      return;
    end
    if (init_left > 0) begin
      m_out = init_left > 1 ? 16'h000C : 16'h0000;
      init_left--;
    end else if (wr_left > 0) begin
      m_out = q.pop_front();
      wr_left--;
    end else if (rd_left > 0) begin
      m_out = 16'h0000;
      m_win = 1'b1;
      rd_left--;
    end else if (q.size() == 0) begin
      m_out = 16'h0000;
    end else begin
      h = q[0];
      if (h[1:0] == 2'b11 && h[2] && q.size() < BW + 1) m_out = 16'h0000;
      else begin
        m_out = q.pop_front();
        if (h[1:0] == 2'b11) begin
          if (h[2]) wr_left = BW;
          else rd_left = BW;
        end
      end
    end
    if (pushing) q.push_back(d);
  endtask

  task automatic step(input logic r, input logic v, input logic [15:0] d);
    @(negedge clk);
    reset_in = r;
    valid = v;
    instr_in = d;
    #1;
    chk("ready", {31'b0, ready}, {31'b0, !r && q.size() < DEPTH});
    @(posedge clk);
    model_edge(r, v, d);
    #1;
    chk("out", {16'b0, out}, {16'b0, m_out});
    chk("count", {27'b0, count}, q.size());
    chk("busy", {31'b0, busy}, {31'b0, init_left > 0 || wr_left > 0 || rd_left > 0});
    chk("window", {31'b0, win}, {31'b0, m_win});
  endtask

  typedef struct {
    logic r, v;
    logic [15:0] d, e_out;
    int e_count;
    logic e_busy, e_win;
  } vec_t;
  vec_t tbl[7];
  logic [15:0] seen[$];
  logic [15:0] exp_seq[$];
  logic [31:0] rnd;
  logic [15:0] d;
  int guard;

  initial begin
    tbl[0] = '{1, 0, 16'h0000, 16'h000C, 0, 1, 0};
    tbl[1] = '{0, 0, 16'h0000, 16'h000C, 0, 1, 0};
    tbl[2] = '{0, 0, 16'h0000, 16'h0000, 0, 0, 0};
    tbl[3] = '{0, 1, 16'h1A09, 16'h0000, 1, 0, 0};
    tbl[4] = '{0, 1, 16'h0005, 16'h1A09, 1, 0, 0};
    tbl[5] = '{0, 0, 16'h0000, 16'h0005, 0, 0, 0};
    tbl[6] = '{0, 0, 16'h0000, 16'h0000, 0, 0, 0};
    for (int i = 0; i < 7; i++) begin
      step(tbl[i].r, tbl[i].v, tbl[i].d);
      chk($sformatf("tbl%0d_out", i), {16'b0, out}, {16'b0, tbl[i].e_out});
      chk($sformatf("tbl%0d_count", i), {27'b0, count}, tbl[i].e_count);
      chk($sformatf("tbl%0d_busy", i), {31'b0, busy}, {31'b0, tbl[i].e_busy});
      chk($sformatf("tbl%0d_win", i), {31'b0, win}, {31'b0, tbl[i].e_win});
    end
    // burst write stalls until all payload words are buffered
    step(0, 1, 16'h0007);
    for (int i = 1; i <= 3; i++) step(0, 1, 16'hA000 + 16'(i));
    chk("stall_out", {16'b0, out}, 32'h0);
    chk("stall_count", {27'b0, count}, 4);
    for (int i = 4; i <= 5; i++) step(0, 1, 16'hA000 + 16'(i));
    seen.delete();
    for (int i = 0; i < 7; i++) begin
      step(0, 0, 16'h0);
      seen.push_back(out);
    end
    exp_seq = '{16'h0007, 16'hA001, 16'hA002, 16'hA003, 16'hA004, 16'hA005, 16'h0000};
    for (int i = 0; i < 7; i++) chk($sformatf("bw_seq%0d", i), {16'b0, seen[i]}, {16'b0, exp_seq[i]});
    // burst read holds issue for the window
    step(0, 1, 16'h0003);
    step(0, 1, 16'h1A09);
    chk("br_head", {16'b0, out}, 32'h0003);
    for (int i = 0; i < BW; i++) begin
      step(0, 0, 16'h0);
      chk($sformatf("br_nop%0d", i), {15'b0, win, out}, 32'h10000);
    end
    step(0, 0, 16'h0);
    chk("br_after", {15'b0, win, out}, 32'h1A09);
    // fill the FIFO behind chained burst reads
    guard = 0;
    while (count != 5'd16 && guard < 100) begin
      step(0, 1, 16'h0003);
      guard++;
    end
    chk("fill_reached", {27'b0, count}, 16);
    chk("full_ready", {31'b0, ready}, 0);
    for (int i = 0; i < 12; i++) step(0, 1, 16'h1A09);
    for (int i = 0; i < 80; i++) step(0, 0, 16'h0);
    // reset in the middle of a burst write payload
    step(0, 1, 16'h000F);
    for (int i = 1; i <= 5; i++) step(0, 1, 16'hB000 + 16'(i));
    step(0, 0, 16'h0);
    chk("bw2_head", {16'b0, out}, 32'h000F);
    step(0, 0, 16'h0);
    step(0, 0, 16'h0);
    step(1, 0, 16'h0);
    chk("abort_out", {16'b0, out}, 32'h000C);
    chk("abort_count", {27'b0, count}, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 16'h0);
    chk("abort_idle", {16'b0, out}, 32'h0);
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rnd = $urandom;
      case (rnd[17:16])
        2'd0: d = {rnd[15:3], 3'b111};
        2'd1: d = {rnd[15:3], 3'b011};
        default: d = (rnd[1:0] == 2'b11) ? {rnd[15:2], 2'b01} : rnd[15:0];
      endcase
      step($urandom_range(0, 249) == 0, $urandom_range(0, 9) < 7, d);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
